// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush control for the RV32I pipeline: load-use interlock, redirect squash, data-memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int WAIT_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_load,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic        ex_redirect,
   input  logic        dmem_req,
   input  logic        dmem_valid,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        id_ex_stall,
   output logic        ex_mem_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic [1:0]  state,
   output logic        mem_timeout,
   output logic [31:0] load_use_cnt,
   output logic [31:0] redirect_cnt,
   output logic [31:0] wait_cnt
);

   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_t;

   state_t      cur, nxt;
   logic        pending_flush;
   logic [31:0] wait_len;
   logic        freeze, eff_flush, load_use;
   logic        take_redirect, lu_stall, kill, stall_all;

   assign state = cur;

   // Leaving MEM_WAIT with a deferred flush behaves exactly like a FLUSH cycle.
   assign freeze    = dmem_req & ~dmem_valid;
   assign eff_flush = (cur == FLUSH) | ((cur == MEM_WAIT) & pending_flush);
   assign load_use  = ex_load & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

   assign take_redirect = ~rst & ~freeze & ~eff_flush & ex_redirect;
   assign lu_stall      = ~rst & ~freeze & ~eff_flush & ~ex_redirect & load_use;
   assign kill          = ~rst & ~freeze & (eff_flush | ex_redirect);
   assign stall_all     = ~rst & freeze;

   assign pc_stall     = stall_all | lu_stall;
   assign if_id_stall  = stall_all | lu_stall;
   assign id_ex_stall  = stall_all;
   assign ex_mem_stall = stall_all;
   assign if_id_flush  = kill;
   assign id_ex_flush  = kill | lu_stall;

   always_comb begin
      nxt = RUN;
      if (freeze)             nxt = MEM_WAIT;
      else if (take_redirect) nxt = FLUSH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur           <= RUN;
         pending_flush <= 1'b0;
         wait_len      <= 32'd0;
         mem_timeout   <= 1'b0;
      end else begin
         cur <= nxt;
         // A redirect or flush interrupted by a freeze must be replayed on exit.
         if (freeze) begin
            if ((cur == FLUSH) || ex_redirect) pending_flush <= 1'b1;
         end else if (cur == MEM_WAIT) begin
            pending_flush <= 1'b0;
         end
         if ((cur == MEM_WAIT) && (nxt == MEM_WAIT)) begin
            if (wait_len < 32'(WAIT_TIMEOUT)) wait_len <= wait_len + 32'd1;
         end else begin
            wait_len <= 32'd0;
         end
         if ((cur == MEM_WAIT) && (wait_len >= 32'(WAIT_TIMEOUT - 1))) mem_timeout <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         load_use_cnt <= 32'd0;
         redirect_cnt <= 32'd0;
         wait_cnt     <= 32'd0;
      end else begin
         if (lu_stall && (load_use_cnt != 32'hFFFF_FFFF))      load_use_cnt <= load_use_cnt + 32'd1;
         if (take_redirect && (redirect_cnt != 32'hFFFF_FFFF)) redirect_cnt <= redirect_cnt + 32'd1;
         if (freeze && (wait_cnt != 32'hFFFF_FFFF))            wait_cnt     <= wait_cnt + 32'd1;
      end
   end
`else
   assign load_use_cnt = 32'd0;
   assign redirect_cnt = 32'd0;
   assign wait_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_load = 0, id_rs1_used = 0, id_rs2_used = 0, ex_redirect = 0;
   logic        dmem_req = 0, dmem_valid = 0;
   logic [4:0]  ex_rd = 0, id_rs1 = 0, id_rs2 = 0;
   logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush;
   logic [1:0]  state;
   logic        mem_timeout;
   logic [31:0] load_use_cnt, redirect_cnt, wait_cnt;

   int n_chk = 0;
   int n_fail = 0;

   pipeline_hazard_ctrl #(.WAIT_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .ex_load(ex_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_redirect(ex_redirect),
      .dmem_req(dmem_req), .dmem_valid(dmem_valid), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .state(state), .mem_timeout(mem_timeout),
      .load_use_cnt(load_use_cnt), .redirect_cnt(redirect_cnt), .wait_cnt(wait_cnt));

   always #5 clk = ~clk;

   // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush}
   wire [5:0] outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};

   typedef struct {
      logic       ld;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, redir, req, vld;
      logic [5:0] exp_out;
      logic [1:0] exp_st;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [31:0] cexp(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      ex_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      ex_redirect = 0; dmem_req = 0; dmem_valid = 0;
   endtask

   task automatic lu_stim();
      ex_load = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1;
   endtask

   task automatic do_reset();
      @(negedge clk); idle(); rst = 1;
      @(negedge clk); rst = 0;
   endtask

   initial begin
      //            ld rd  rs1 rs2 u1 u2 rdr req vld  out        st
      vecs[0]  = '{0, 0,  0,  0,  0, 0, 0,  0,  0,  6'b000000, 2'd0};
      vecs[1]  = '{1, 5,  0,  5,  0, 1, 0,  0,  0,  6'b110001, 2'd0};
      vecs[2]  = '{1, 0,  0,  0,  1, 1, 0,  0,  0,  6'b000000, 2'd0};
      vecs[3]  = '{1, 7,  7,  2,  1, 0, 0,  0,  0,  6'b110001, 2'd0};
      vecs[4]  = '{1, 7,  7,  2,  0, 1, 0,  0,  0,  6'b000000, 2'd0};
      vecs[5]  = '{0, 7,  7,  7,  1, 1, 0,  0,  0,  6'b000000, 2'd0};
      vecs[6]  = '{1, 3,  4,  5,  1, 1, 0,  0,  0,  6'b000000, 2'd0};
      vecs[7]  = '{0, 0,  0,  0,  0, 0, 1,  0,  0,  6'b000011, 2'd1};
      vecs[8]  = '{1, 5,  0,  5,  0, 1, 1,  0,  0,  6'b000011, 2'd1};
      vecs[9]  = '{0, 0,  0,  0,  0, 0, 0,  1,  0,  6'b111100, 2'd2};
      vecs[10] = '{1, 5,  5,  0,  1, 0, 1,  1,  0,  6'b111100, 2'd2};
      vecs[11] = '{1, 5,  5,  0,  1, 0, 0,  1,  1,  6'b110001, 2'd0};

      // Outputs held low while reset is asserted, then clean RUN state.
      @(negedge clk); lu_stim(); ex_redirect = 1; dmem_req = 1; #1;
      chk("rst_outs", 32'(outs), 32'd0);
      do_reset(); #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_outs_idle", 32'(outs), 32'd0);
      chk("rst_tmo", 32'(mem_timeout), 32'd0);
      chk("rst_cnts", load_use_cnt | redirect_cnt | wait_cnt, 32'd0);

      for (int i = 0; i < 12; i++) begin
         do_reset();
         ex_load = vecs[i].ld; ex_rd = vecs[i].rd; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
         id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2; ex_redirect = vecs[i].redir;
         dmem_req = vecs[i].req; dmem_valid = vecs[i].vld;
         #1 chk($sformatf("vec%0d_out", i), 32'(outs), 32'(vecs[i].exp_out));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_st));
      end

      // Redirect pulse: two flush cycles, states 0,1,0.
      do_reset();
      ex_redirect = 1; #1;
      chk("redir_c0_out", 32'(outs), 32'b000011); chk("redir_c0_st", 32'(state), 32'd0);
      @(negedge clk); ex_redirect = 0; lu_stim(); #1;
      chk("redir_c1_out", 32'(outs), 32'b000011); chk("redir_c1_st", 32'(state), 32'd1);
      @(negedge clk); idle(); #1;
      chk("redir_c2_out", 32'(outs), 32'd0); chk("redir_c2_st", 32'(state), 32'd0);
      chk("redir_cnt", redirect_cnt, cexp(1));
      chk("redir_lu_cnt", load_use_cnt, cexp(0));

      // Three-cycle memory wait then completion.
      do_reset();
      dmem_req = 1; dmem_valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("wait%0d_out", i), 32'(outs), 32'b111100);
         chk($sformatf("wait%0d_st", i), 32'(state), (i == 0) ? 32'd0 : 32'd2);
         @(negedge clk);
      end
      dmem_valid = 1; #1;
      chk("wait_done_out", 32'(outs), 32'd0); chk("wait_done_st", 32'(state), 32'd2);
      @(negedge clk); idle(); #1;
      chk("wait_exit_st", 32'(state), 32'd0);
      chk("wait_cnt", wait_cnt, cexp(3));

      // Freeze landing on the FLUSH cycle replays one flush on completion.
      do_reset();
      ex_redirect = 1; #1;
      chk("ff_c0_out", 32'(outs), 32'b000011);
      @(negedge clk); ex_redirect = 0; dmem_req = 1; dmem_valid = 0; #1;
      chk("ff_c1_out", 32'(outs), 32'b111100); chk("ff_c1_st", 32'(state), 32'd1);
      @(negedge clk); #1;
      chk("ff_c2_out", 32'(outs), 32'b111100); chk("ff_c2_st", 32'(state), 32'd2);
      @(negedge clk); dmem_valid = 1; lu_stim(); #1;
      chk("ff_c3_out", 32'(outs), 32'b000011); chk("ff_c3_st", 32'(state), 32'd2);
      @(negedge clk); dmem_req = 0; dmem_valid = 0; #1;
      chk("ff_c4_out", 32'(outs), 32'b110001); chk("ff_c4_st", 32'(state), 32'd0);
      @(negedge clk); idle();
      // A second wait with no redirect must not flush: pending was cleared.
      dmem_req = 1; @(negedge clk); dmem_valid = 1; #1;
      chk("ff_noreplay_out", 32'(outs), 32'd0);
      @(negedge clk); idle(); #1;
      chk("ff_redir_cnt", redirect_cnt, cexp(1));
      chk("ff_wait_cnt", wait_cnt, cexp(3));

      // Timeout: six frozen cycles with WAIT_TIMEOUT=4.
      do_reset();
      dmem_req = 1; dmem_valid = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk($sformatf("tmo%0d", i), 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
      end
      @(negedge clk); dmem_valid = 1; #1;
      chk("tmo_exit_out", 32'(outs), 32'd0);
      @(negedge clk); idle(); #1;
      chk("tmo_exit_st", 32'(state), 32'd0);
      chk("tmo_sticky", 32'(mem_timeout), 32'd1);
      @(negedge clk); #1;
      chk("tmo_sticky2", 32'(mem_timeout), 32'd1);
      do_reset(); #1;
      chk("tmo_cleared", 32'(mem_timeout), 32'd0);

      // Two load-use cycles, then reset in the middle of a wait.
      @(negedge clk); lu_stim();
      @(negedge clk); #1;
      chk("lu2_st", 32'(state), 32'd0);
      @(negedge clk); idle(); #1;
      chk("lu_cnt", load_use_cnt, cexp(2));
      dmem_req = 1; ex_redirect = 1;
      @(negedge clk); #1;
      chk("rmw_st", 32'(state), 32'd2);
      rst = 1; #1;
      chk("rmw_outs", 32'(outs), 32'd0);
      @(posedge clk); #1;
      chk("rmw_state", 32'(state), 32'd0);
      chk("rmw_cnts", load_use_cnt | redirect_cnt | wait_cnt, 32'd0);
      @(negedge clk); rst = 0; dmem_req = 0; ex_redirect = 0; #1;
      chk("rmw_no_pending", 32'(outs), 32'd0);
      @(negedge clk); #1;
      chk("rmw_idle_st", 32'(state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
